// File: rtl/vt52_uart_pkg.sv
// Shared UART definitions: software flow-control characters and the
// flow-control state encoding used by the receive buffer.
package vt52_uart_pkg;

    localparam logic [7:0] XON_CHAR  = 8'h11;
    localparam logic [7:0] XOFF_CHAR = 8'h13;

    typedef enum logic [1:0] {
        FC_ON,
        FC_SEND_XOFF,
        FC_OFF,
        FC_SEND_XON
    } fc_state_t;

endpackage

// File: rtl/rx_flow_buffer_sync_fifo.sv
// sync_fifo: first-word-fall-through byte FIFO with a separate occupancy
// counter; the caller must never push while full or pop while empty.
module sync_fifo
    import vt52_uart_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [7:0]        wr_data,
    output logic [7:0]        rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

    logic [7:0]        mem_reg [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   count_reg;

    // Storage has no reset so it maps onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + COUNT_ONE;
                2'b01:   count_reg <= count_reg - COUNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rd_data = mem_reg[rd_ptr_reg];
    assign full    = (count_reg == FULL_COUNT);
    assign empty   = (count_reg == '0);
    assign count   = count_reg;

endmodule

// File: rtl/rx_flow_buffer.sv
// UART receive buffer with XON/XOFF generation on watermarks.
// Define RX_FLOW_REMOTE_XONXOFF_EN to consume host XON/XOFF into remote_paused.
module rx_flow_buffer
    import vt52_uart_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int ADDR_W     = 6,
    parameter int HIGH_WATER = 48,
    parameter int LOW_WATER  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        fc_data,
    output logic              fc_valid,
    input  logic              fc_ready,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              remote_paused
);

    localparam logic [ADDR_W:0] HIGH_COUNT = (ADDR_W+1)'(HIGH_WATER);
    localparam logic [ADDR_W:0] LOW_COUNT  = (ADDR_W+1)'(LOW_WATER);

    logic      full;
    logic      empty;
    logic      push;
    logic      pop;
    logic      is_ctrl;
    logic      overflow_reg;
    fc_state_t state_reg;
    fc_state_t state_next;

`ifdef RX_FLOW_REMOTE_XONXOFF_EN
    logic remote_paused_reg;

    assign is_ctrl = (in_data == XON_CHAR) || (in_data == XOFF_CHAR);

    // Host flow-control bytes are swallowed, never stored or counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            remote_paused_reg <= 1'b0;
        end else if (in_valid && in_ready && is_ctrl) begin
            remote_paused_reg <= (in_data == XOFF_CHAR);
        end
    end

    assign remote_paused = remote_paused_reg;
`else
    assign is_ctrl       = 1'b0;
    assign remote_paused = 1'b0;
`endif

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && !full && !is_ctrl;
    assign pop       = out_valid && out_ready;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (in_data),
        .rd_data (out_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_reg <= 1'b0;
        end else if (in_valid && full && !is_ctrl) begin
            overflow_reg <= 1'b1;
        end
    end

    assign overflow = overflow_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= FC_ON;
        end else begin
            state_reg <= state_next;
        end
    end

    // Watermarks are checked against the registered count, so a request
    // appears one cycle after the count update that crossed the threshold.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            FC_ON:        if (count >= HIGH_COUNT) state_next = FC_SEND_XOFF;
            FC_SEND_XOFF: if (fc_ready)            state_next = FC_OFF;
            FC_OFF:       if (count <= LOW_COUNT)  state_next = FC_SEND_XON;
            FC_SEND_XON:  if (fc_ready)            state_next = FC_ON;
            default:      state_next = FC_ON;
        endcase
    end

    // Decoded purely from the state register, so both outputs are glitch-free
    // and cannot change while a byte is pending.
    always_comb begin
        fc_valid = (state_reg == FC_SEND_XOFF) || (state_reg == FC_SEND_XON);
        fc_data  = ((state_reg == FC_SEND_XOFF) || (state_reg == FC_OFF)) ? XOFF_CHAR : XON_CHAR;
    end

endmodule

// File: tb/tb_rx_flow_buffer.sv
// Self-checking bench for rx_flow_buffer: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_rx_flow_buffer;
    import vt52_uart_pkg::*;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam int HW     = 48;
    localparam int LW     = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [7:0]        fc_data;
    logic              fc_valid;
    logic              fc_ready = 1'b0;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              remote_paused;

    rx_flow_buffer #(
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .HIGH_WATER (HW),
        .LOW_WATER  (LW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .fc_data       (fc_data),
        .fc_valid      (fc_valid),
        .fc_ready      (fc_ready),
        .count         (count),
        .overflow      (overflow),
        .remote_paused (remote_paused)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus "host told to stop" / "byte pending" flags.
    byte unsigned q[$];
    bit           m_live = 1'b0;
    bit           m_ovf, m_rp, m_pend, m_stopped;
    logic [7:0]   m_fcd;

    always @(posedge clk) begin
        int  c;
        bit  is_full, ctrl, acc, do_pop;
        if (reset) begin
            q.delete();
            m_ovf = 0; m_rp = 0; m_pend = 0; m_stopped = 0;
            m_fcd = 8'h11;
            m_live = 1;
        end else if (m_live) begin
            c = q.size();
            is_full = (c == DEPTH);
            ctrl = 0;
`ifdef RX_FLOW_REMOTE_XONXOFF_EN
            ctrl = (in_data == 8'h11) || (in_data == 8'h13);
`endif
            acc    = in_valid && !is_full;
            do_pop = (c > 0) && out_ready;
            if (m_pend) begin
                if (fc_ready) m_pend = 0;
            end else if (!m_stopped && c >= HW) begin
                m_pend = 1; m_fcd = 8'h13; m_stopped = 1;
            end else if (m_stopped && c <= LW) begin
                m_pend = 1; m_fcd = 8'h11; m_stopped = 0;
            end
            if (in_valid && is_full && !ctrl) m_ovf = 1;
            if (acc && ctrl) m_rp = (in_data == 8'h13);
            if (do_pop) void'(q.pop_front());
            if (acc && !ctrl) q.push_back(in_data);
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("in_ready", in_ready, q.size() != DEPTH);
            check("count", count, q.size());
            check("out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) check("out_data", out_data, q[0]);
            check("fc_valid", fc_valid, m_pend);
            check("fc_data", fc_data, m_fcd);
            check("overflow", overflow, m_ovf);
            check("remote_paused", remote_paused, m_rp);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] v;
        do v = 8'($urandom_range(0, 255));
        while (v == 8'h11 || v == 8'h13 || v == 8'h5A);
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp3 [3];
        int hs, seen;
        int p_push, p_pop;
        exp3[0] = 8'h41; exp3[1] = 8'h42; exp3[2] = 8'h43;

        // Reset state
        reset = 1; cyc(); cyc(); reset = 0;
        check("rst_count", count, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_fc_valid", fc_valid, 0);
        check("rst_fc_data", fc_data, 8'h11);
        check("rst_overflow", overflow, 0);
        check("rst_remote_paused", remote_paused, 0);

        // Three bytes in, then drained in order
        for (int i = 0; i < 3; i++) begin
            in_data = exp3[i]; in_valid = 1; cyc();
        end
        in_valid = 0;
        check("burst_count", count, 3);
        check("burst_head", out_data, 8'h41);
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            check("burst_order", out_data, exp3[i]);
            cyc();
        end
        out_ready = 0;
        check("burst_empty", count, 0);
        $display("test: basic FIFO order done");

        // High watermark -> XOFF held until accepted
        for (int i = 0; i < HW; i++) begin
            in_data = rand_byte(); in_valid = 1; cyc();
        end
        in_valid = 0;
        check("hw_count", count, HW);
        check("hw_no_early_fc", fc_valid, 0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            check("xoff_valid", fc_valid, 1);
            check("xoff_data", fc_data, 8'h13);
            cyc();
        end
        fc_ready = 1; cyc(); fc_ready = 0;
        check("xoff_accepted", fc_valid, 0);
        $display("test: XOFF generation done");

        // Drain to low watermark -> exactly one XON
        out_ready = 1;
        for (int i = 0; i < HW - LW; i++) cyc();
        out_ready = 0;
        check("lw_count", count, LW);
        check("lw_no_early_fc", fc_valid, 0);
        cyc();
        check("xon_valid", fc_valid, 1);
        check("xon_data", fc_data, 8'h11);
        hs = 0;
        fc_ready = 1;
        for (int i = 0; i < 5; i++) begin
            if (fc_valid && fc_ready) hs++;
            cyc();
        end
        check("xon_once", hs, 1);
        $display("test: XON generation done");

        // Fill completely, overflow on extra byte
        for (int i = 0; i < DEPTH - LW; i++) begin
            in_data = rand_byte(); in_valid = 1; cyc();
        end
        check("full_count", count, DEPTH);
        check("full_in_ready", in_ready, 0);
        in_data = 8'h5A;
        cyc(); cyc();
        in_valid = 0;
        check("ovf_set", overflow, 1);
        check("ovf_count", count, DEPTH);
        seen = 0;
        out_ready = 1;
        for (int i = 0; i < DEPTH; i++) begin
            if (out_data == 8'h5A) seen++;
            cyc();
        end
        out_ready = 0;
        check("ovf_dropped_byte", seen, 0);
        check("ovf_sticky", overflow, 1);
        check("drained", count, 0);
        reset = 1; cyc(); reset = 0;
        check("ovf_cleared", overflow, 0);
        $display("test: overflow done");

        // Simultaneous push/pop at constant occupancy
        for (int i = 0; i < 10; i++) begin
            in_data = rand_byte(); in_valid = 1; cyc();
        end
        out_ready = 1;
        for (int i = 0; i < 20; i++) begin
            in_data = rand_byte(); cyc();
            check("steady_count", count, 10);
        end
        in_valid = 0;
        for (int i = 0; i < 10; i++) cyc();
        out_ready = 0;
        check("steady_drained", count, 0);
        $display("test: simultaneous push/pop done");

`ifdef RX_FLOW_REMOTE_XONXOFF_EN
        reset = 1; cyc(); reset = 0;
        in_valid = 1;
        in_data = 8'h13; cyc();
        check("rp_set", remote_paused, 1);
        check("rp_not_stored", count, 0);
        in_data = 8'h41; cyc();
        in_data = 8'h11; cyc();
        in_valid = 0;
        check("rp_clear", remote_paused, 0);
        check("rp_count", count, 1);
        check("rp_data", out_data, 8'h41);
        out_ready = 1; cyc(); out_ready = 0;
        $display("test: remote XON/XOFF done");
`endif

        // Randomized traffic in epochs of varying push/pop bias
        for (int e = 0; e < 15; e++) begin
            p_push = $urandom_range(10, 95);
            p_pop  = $urandom_range(10, 95);
            for (int i = 0; i < 200; i++) begin
                reset     = ($urandom_range(0, 799) == 0);
                in_valid  = ($urandom_range(0, 99) < p_push);
                in_data   = 8'($urandom_range(0, 255));
                out_ready = ($urandom_range(0, 99) < p_pop);
                fc_ready  = ($urandom_range(0, 1) == 1);
                cyc();
            end
            $display("test: random epoch %0d push%%=%0d pop%%=%0d count=%0d", e, p_push, p_pop, count);
        end
        reset = 0; in_valid = 0; out_ready = 0; fc_ready = 0;
        cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rx_flow_buffer.md
Name: rx_flow_buffer

Overview:
Receive buffer between the UART RX data port and the input multiplexer's UART leg. It absorbs bursts from the host while the command handler stalls, for example during scroll or clear operations. It generates XON/XOFF software flow control bytes for the UART TX arbiter when the buffer crosses watermarks. With an option compiled in, it also consumes XON/XOFF bytes sent by the host.

Parameters:
- DEPTH, 64, FIFO entries; must be a power of 2 and at least 8.
- ADDR_W, 6, log2(DEPTH).
- HIGH_WATER, 48, occupancy at or above which XOFF is requested.
- LOW_WATER, 16, occupancy at or below which XON is requested; must be less than HIGH_WATER.

Ports:
- clk, in, 1: system clock (25 MHz).
- reset, in, 1: synchronous, active-high.
- in_data, in, 8: byte from the UART receiver.
- in_valid, in, 1: in_data is valid.
- in_ready, out, 1: buffer can accept; equals !full.
- out_data, out, 8: head byte sent to the multiplexer.
- out_valid, out, 1: buffer is not empty.
- out_ready, in, 1: multiplexer consumes the head byte.
- fc_data, out, 8: flow-control byte, 8'h13 (XOFF) or 8'h11 (XON).
- fc_valid, out, 1: fc_data is pending.
- fc_ready, in, 1: TX arbiter accepts fc_data.
- count, out, ADDR_W+1: current occupancy, 0..DEPTH.
- overflow, out, 1: sticky flag, set when a byte is dropped.
- remote_paused, out, 1: host has sent XOFF (optional feature only).

Behaviour:
- Reset values: pointers 0, count 0, out_valid 0, in_ready 1, fc_valid 0, fc_data 8'h11, overflow 0, remote_paused 0, FSM in FC_ON. Reset mid-transfer discards all contents and any pending flow-control byte.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- The FIFO is first-word-fall-through. out_data reads mem[rd_ptr] combinationally. A byte written in cycle N appears on out_valid/out_data in cycle N+1.
- Pointers are ADDR_W bits and wrap modulo DEPTH. count is a separate register: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- When full: in_ready=0. A push is refused even if a pop happens in the same cycle.
- When empty: out_valid=0 and out_data is don't-care.
- Overflow: in_valid while full drops the byte and sets overflow=1. overflow stays set until reset.
- Flow-control FSM, evaluated on the registered count:
  - FC_ON: if count >= HIGH_WATER, go to FC_SEND_XOFF.
  - FC_SEND_XOFF: fc_valid=1, fc_data=8'h13. On fc_ready, go to FC_OFF.
  - FC_OFF: if count <= LOW_WATER, go to FC_SEND_XON.
  - FC_SEND_XON: fc_valid=1, fc_data=8'h11. On fc_ready, go to FC_ON.
  - fc_valid and fc_data are registered and held stable until accepted. A pending byte is never withdrawn or changed.
  - If count reaches HIGH_WATER while in FC_SEND_XON, the XON still completes. The FSM then enters FC_ON and, if count >= HIGH_WATER, moves to FC_SEND_XOFF the next cycle.
- fc_valid asserts exactly one cycle after the count update that crossed the watermark.

Optional Feature:
- Macro RX_FLOW_REMOTE_XONXOFF_EN.
- When defined:
  - An incoming 8'h13 is not stored; it sets remote_paused=1.
  - An incoming 8'h11 is not stored; it clears remote_paused.
  - Both are handshaken (in_ready honoured) and take effect the next cycle.
  - They do not change count and are dropped even when full, without setting overflow.
- When undefined: all bytes are stored as data and remote_paused is tied to 0.

Decomposition:
- Package vt52_uart_pkg:
  - constants XON_CHAR=8'h11 and XOFF_CHAR=8'h13;
  - fc_state_t enum {FC_ON, FC_SEND_XOFF, FC_OFF, FC_SEND_XON}.
- Sub-module sync_fifo (parameterised DEPTH and ADDR_W; push/pop/full/empty/count). rx_flow_buffer wraps it with the flow-control FSM and optional filter.

Test Plan:
- Reset, then push 0x41,0x42,0x43 with out_ready=0. Expect count=3 and out_data=0x41. Raise out_ready for 3 cycles; expect the bytes in order and count=0.
- Push 48 bytes with out_ready=0 and fc_ready=0. Expect fc_valid=1 and fc_data=0x13, held stable. Pulse fc_ready; expect fc_valid=0 next cycle.
- From the XOFF state, pop until count=16. Expect fc_data=0x11 and fc_valid=1, exactly one XON.
- Fill to 64 and drive 0x5A again. Expect in_ready=0, 0x5A absent from output, and overflow=1 until reset.
- Simultaneous push and pop at count=10 for 20 cycles. Expect count to stay 10 and data order preserved across pointer wrap.
- With RX_FLOW_REMOTE_XONXOFF_EN, send 0x13, 0x41, 0x11. Expect remote_paused to go 1 then 0, and only 0x41 to be output.
